// File: rtl/vga_timing_pkg.sv
// Shared definitions for the raster timing generator: FSM encoding and
// standard video mode timings.
package vga_timing_pkg;

   // Generator control state: waiting for the first pixel, or scanning.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } vga_state_e;

   // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs.
   localparam int unsigned VGA640_H_ACTIVE = 640;
   localparam int unsigned VGA640_H_FP     = 16;
   localparam int unsigned VGA640_H_SYNC   = 96;
   localparam int unsigned VGA640_H_BP     = 48;
   localparam int unsigned VGA640_V_ACTIVE = 480;
   localparam int unsigned VGA640_V_FP     = 10;
   localparam int unsigned VGA640_V_SYNC   = 2;
   localparam int unsigned VGA640_V_BP     = 33;
   localparam logic        VGA640_H_POL    = 1'b0;
   localparam logic        VGA640_V_POL    = 1'b0;

   // 1280x720 @ 60 Hz (74.25 MHz pixel clock), positive syncs.
   localparam int unsigned HD720_H_ACTIVE  = 1280;
   localparam int unsigned HD720_H_FP      = 110;
   localparam int unsigned HD720_H_SYNC    = 40;
   localparam int unsigned HD720_H_BP      = 220;
   localparam int unsigned HD720_V_ACTIVE  = 720;
   localparam int unsigned HD720_V_FP      = 5;
   localparam int unsigned HD720_V_SYNC    = 5;
   localparam int unsigned HD720_V_BP      = 20;
   localparam logic        HD720_H_POL     = 1'b1;
   localparam logic        HD720_V_POL     = 1'b1;

   // Positions per axis (line length or frame height).
   function automatic int unsigned axis_total(input int unsigned active,
                                              input int unsigned fp,
                                              input int unsigned sync,
                                              input int unsigned bp);
      return active + fp + sync + bp;
   endfunction

endpackage : vga_timing_pkg

// File: rtl/timing_axis_counter.sv
// One raster axis: position counter that wraps at the axis total, plus
// region decode for the active and sync windows.
module timing_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned ACTIVE = 640,
   parameter int unsigned FP     = 16,
   parameter int unsigned SYNC   = 96,
   parameter int unsigned BP     = 48
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        advance_i,
   input  logic        load_zero_i,
   output logic [15:0] count_o,
   output logic        wrap_o,
   output logic        in_active_o,
   output logic        in_sync_o
);

   localparam int unsigned TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [15:0] LAST       = 16'(TOTAL - 1);
   localparam logic [15:0] ACT_LIMIT  = 16'(ACTIVE);
   localparam logic [15:0] SYNC_FIRST = 16'(ACTIVE + FP);
   localparam logic [15:0] SYNC_LAST  = 16'(ACTIVE + FP + SYNC - 1);

   logic [15:0] count_q, count_d;

   // Next position: forced to zero on load, otherwise step and wrap at LAST.
   always_comb begin
      count_d = count_q;
      if (load_zero_i) begin
         count_d = '0;
      end else if (advance_i) begin
         count_d = (count_q == LAST) ? '0 : count_q + 16'd1;
      end
   end

   // Position register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

   // Terminal position: the next advance wraps this axis.
   assign wrap_o = (count_q == LAST);

   // Region flags decode the next position so that the parent can register
   // them on the same edge the counter moves, keeping them aligned with it.
   assign in_active_o = (count_d < ACT_LIMIT);
   assign in_sync_o   = (count_d >= SYNC_FIRST) && (count_d <= SYNC_LAST);

endmodule : timing_axis_counter

// File: rtl/vga_timing_gen.sv
// Raster timing generator: x/y position, syncs, data enable and line/frame
// strobes, advancing one pixel per i_pix_en-qualified clock.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
   parameter int unsigned H_FP     = VGA640_H_FP,
   parameter int unsigned H_SYNC   = VGA640_H_SYNC,
   parameter int unsigned H_BP     = VGA640_H_BP,
   parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
   parameter int unsigned V_FP     = VGA640_V_FP,
   parameter int unsigned V_SYNC   = VGA640_V_SYNC,
   parameter int unsigned V_BP     = VGA640_V_BP,
   parameter logic        H_POL    = VGA640_H_POL,
   parameter logic        V_POL    = VGA640_V_POL
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pix_en,
   output logic [15:0] o_x,
   output logic [15:0] o_y,
   output logic        o_h_sync,
   output logic        o_v_sync,
   output logic        o_de,
   output logic        o_line_start,
   output logic        o_frame_start
);

   vga_state_e state_q, state_d;

   logic load, advance;
   logic h_wrap, h_active, h_sync;
   logic v_wrap, v_active, v_sync;

   logic de_q, de_d;
   logic hs_q, hs_d;
   logic vs_q, vs_d;
   logic line_q, line_d;
   logic frame_q, frame_d;

   // Horizontal axis steps on every qualified pixel.
   timing_axis_counter #(
      .ACTIVE(H_ACTIVE),
      .FP    (H_FP),
      .SYNC  (H_SYNC),
      .BP    (H_BP)
   ) u_h_axis (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .advance_i  (advance),
      .load_zero_i(load),
      .count_o    (o_x),
      .wrap_o     (h_wrap),
      .in_active_o(h_active),
      .in_sync_o  (h_sync)
   );

   // Vertical axis steps only when the horizontal axis wraps.
   timing_axis_counter #(
      .ACTIVE(V_ACTIVE),
      .FP    (V_FP),
      .SYNC  (V_SYNC),
      .BP    (V_BP)
   ) u_v_axis (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .advance_i  (advance & h_wrap),
      .load_zero_i(load),
      .count_o    (o_y),
      .wrap_o     (v_wrap),
      .in_active_o(v_active),
      .in_sync_o  (v_sync)
   );

   // FSM next state plus flag/strobe next values; flags only move with the
   // counters, strobes fall back to zero on any edge without a wrap.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      advance = 1'b0;
      de_d    = de_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      line_d  = 1'b0;
      frame_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (i_pix_en) begin
               load    = 1'b1;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            advance = i_pix_en;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (load || advance) begin
         de_d = h_active & v_active;
         hs_d = h_sync ? H_POL : ~H_POL;
         vs_d = v_sync ? V_POL : ~V_POL;
      end

      line_d  = load | (advance & h_wrap);
      frame_d = load | (advance & h_wrap & v_wrap);
   end

   // State and output registers; reset parks syncs at their idle level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         de_q    <= 1'b0;
         hs_q    <= ~H_POL;
         vs_q    <= ~V_POL;
         line_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         de_q    <= de_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         line_q  <= line_d;
         frame_q <= frame_d;
      end
   end

   assign o_de          = de_q;
   assign o_h_sync      = hs_q;
   assign o_v_sync      = vs_q;
   assign o_line_start  = line_q;
   assign o_frame_start = frame_q;

endmodule : vga_timing_gen

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator that drives the pixel-coordinate side of the gfx compositor.
- Produces x/y position, horizontal and vertical sync, data-enable, and line/frame strobes.
- Sprite and background modules consume the x/y and vertical-sync outputs; the display PHY consumes the syncs and data-enable.
- Advances one pixel per cycle in which i_pix_en is high, so one generic block serves any pixel-clock ratio.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, horizontal sync asserted level (0 = active-low)
- V_POL, 0, vertical sync asserted level (0 = active-low)

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset; asynchronous, active-high
- i_pix_en  in  1  pixel advance qualifier
- o_x  out  16  horizontal position, 0..H_TOTAL-1
- o_y  out  16  vertical position, 0..V_TOTAL-1
- o_h_sync  out  1  horizontal sync at H_POL level when asserted
- o_v_sync  out  1  vertical sync at V_POL level when asserted
- o_de  out  1  high when o_x<H_ACTIVE and o_y<V_ACTIVE
- o_line_start  out  1  one-clock pulse when o_x becomes 0
- o_frame_start  out  1  one-clock pulse when (o_x,o_y) becomes (0,0)

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Legal parameters: every field >=1, each total <=65535. Line order: active, FP, sync, BP.
- All outputs are registers; no combinational path from input to output.
- Reset (async assert, sync release): state=IDLE; o_x=0, o_y=0; o_de=0; strobes=0; syncs at inactive level (~H_POL, ~V_POL).
- FSM states IDLE and RUN:
  - IDLE: outputs hold their reset values. On the first clock edge with i_pix_en=1, load position (0,0), set o_de=1, pulse o_line_start and o_frame_start, and go to RUN.
  - RUN: on each edge with i_pix_en=1, advance the position.
    - o_x<H_TOTAL-1: o_x+1.
    - Otherwise o_x=0 and o_line_start pulses.
      - If o_y<V_TOTAL-1: o_y+1.
      - Otherwise o_y=0 and o_frame_start also pulses.
  - RUN never returns to IDLE except through reset.
- Sync and data-enable alignment: o_h_sync, o_v_sync and o_de are updated on the same edge as o_x/o_y and always describe the position currently on o_x/o_y. Latency between position and these flags is zero.
- o_h_sync is asserted when H_ACTIVE+H_FP <= o_x <= H_ACTIVE+H_FP+H_SYNC-1.
- o_v_sync is asserted for the whole of every line with V_ACTIVE+V_FP <= o_y <= V_ACTIVE+V_FP+V_SYNC-1, including all horizontal positions of those lines.
- Blanking: o_x/o_y keep counting through blanking (values >= ACTIVE). Consumers gate on o_de.
- i_pix_en low: all position, sync and data-enable outputs hold. Strobes are exactly one i_clk cycle wide and clear on the next edge regardless of i_pix_en.
- Simultaneous wraps: line wrap and frame wrap on the same edge pulse both strobes.
- Reset mid-frame: outputs return to reset values immediately (asynchronously). After release, the next i_pix_en restarts at (0,0) with o_frame_start.
- Arithmetic: counters are 16-bit unsigned and never exceed TOTAL-1, so no overflow is possible.

Decomposition:
- Package vga_timing_pkg holds:
  - FSM state encoding (IDLE, RUN).
  - Mode constants for 640x480@60 (the defaults).
  - Mode constants for 1280x720@60: 1280/110/40/220, 720/5/5/20, positive polarity.
- Sub-module timing_axis_counter, instantiated once per axis.
  - Parameters: ACTIVE, FP, SYNC, BP.
  - Inputs: clk, rst, advance, load_zero.
  - Outputs: count, wrap, in_active, in_sync.
  - The vertical instance advances on the horizontal wrap.

Test Plan:
- Reset, then hold i_pix_en=0 for 10 cycles -> o_x=0, o_y=0, o_de=0, o_h_sync=1, o_v_sync=1, no strobes.
- First i_pix_en pulse -> o_x=0, o_y=0, o_de=1; o_frame_start and o_line_start each high for exactly one clock.
- i_pix_en constant 1 across line 0:
  - o_de falls at o_x=640.
  - o_h_sync low for o_x 656..751 (96 pixels).
  - At o_x=799 the next edge gives o_x=0, o_y=1, and o_line_start pulses.
- i_pix_en constant 1 for a full frame:
  - o_v_sync low exactly on lines 490..491.
  - (799,524) wraps to (0,0) with o_frame_start.
  - Consecutive o_frame_start pulses are 420000 pix_en cycles apart.
- i_pix_en toggling 1-of-4 -> position advances every 4th clock; strobes stay 1 clock wide; outputs hold between advances.
- Assert i_rst at (300,200) asynchronously mid-cycle -> outputs immediately at reset values. After release, the first pix_en gives (0,0) with o_frame_start.
